recovery_pec_checker: RTL and testbench

Receive-side PEC checker for recovery-interface write frames. It sits between the target byte receiver and the recovery command/payload logic. It consumes a byte stream delimited by start/stop events and withholds the final byte of each frame as the PEC. Payload bytes are forwarded downstream with valid/ready, and the PEC is checked against a CRC-8 computed over the payload.

---
 rtl/recovery_pec_checker.sv | 161 ++++++++++++++++
 tb/tb_recovery_pec_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recovery_pec_checker.sv
// Receive-side PEC checker: holds back the last byte of each frame as the PEC,
// forwards the payload over valid/ready and checks it against a CRC-8 (poly 0x07).
module recovery_pec_checker #(
  parameter logic [7:0] PecInit = 8'h00,
  parameter int         LenW    = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [7:0]      in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [7:0]      out_data_o,
  output logic            done_o,
  output logic            pec_ok_o,
  output logic            short_o,
  output logic [LenW-1:0] len_o
);

  // state | meaning
  // IDLE  | outside a frame, incoming bytes are dropped
  // FRAME | collecting bytes, newest byte held back in H
  // DRAIN | frame closed, waiting for O to be consumed before done_o
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]      state_q;
  logic [7:0]      h_q;
  logic            h_valid_q;
  logic [7:0]      crc_q;
  logic [LenW-1:0] cnt_q;
  logic            pend_q;

  logic            in_accept;
  logic            out_hs;
  logic            fwd;
  logic            close;
  logic [7:0]      crc_nx;
  logic [7:0]      h_nx;
  logic            hv_nx;
  logic [LenW-1:0] cnt_nx;
  logic            ov_nx;

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    logic [7:0] n;
    x    = c ^ d;
    n[0] = x[0] ^ x[6] ^ x[7];
    n[1] = x[0] ^ x[1] ^ x[6];
    n[2] = x[0] ^ x[1] ^ x[2] ^ x[6];
    n[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
    n[4] = x[2] ^ x[3] ^ x[4];
    n[5] = x[3] ^ x[4] ^ x[5];
    n[6] = x[4] ^ x[5] ^ x[6];
    n[7] = x[5] ^ x[6] ^ x[7];
    return n;
  endfunction

  always_comb begin
    in_ready_o = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready_o = 1'b1;
      ST_FRAME: in_ready_o = !out_valid_o | out_ready_i;
      default:  in_ready_o = 1'b0;
    endcase
  end

  assign in_accept = in_valid_i & in_ready_o;
  assign out_hs    = out_valid_o & out_ready_i;
  assign close     = (state_q == ST_FRAME) & (start_i | stop_i);

  // Values after this cycle's byte is processed; a close evaluates these.
  always_comb begin
    fwd    = (state_q == ST_FRAME) & in_accept & h_valid_q;
    crc_nx = fwd ? crc_upd(crc_q, h_q) : crc_q;
    h_nx   = in_accept ? in_data_i : h_q;
    hv_nx  = h_valid_q | in_accept;
    cnt_nx = cnt_q;
    if (fwd && (cnt_q != {LenW{1'b1}})) cnt_nx = cnt_q + LenW'(1);
    ov_nx  = fwd | (out_valid_o & !out_ready_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      h_q         <= 8'h00;
      h_valid_q   <= 1'b0;
      crc_q       <= PecInit;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= 8'h00;
      done_o      <= 1'b0;
      pec_ok_o    <= 1'b0;
      short_o     <= 1'b0;
      len_o       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pend_q <= 1'b0;
          if (start_i) begin
            state_q   <= ST_FRAME;
            crc_q     <= PecInit;
            cnt_q     <= '0;
            h_valid_q <= in_valid_i;
            if (in_valid_i) h_q <= in_data_i;
          end
        end
        ST_FRAME: begin
          if (out_hs) out_valid_o <= 1'b0;
          if (fwd) begin
            out_data_o  <= h_q;
            out_valid_o <= 1'b1;
          end
          h_q       <= h_nx;
          h_valid_q <= hv_nx;
          crc_q     <= crc_nx;
          cnt_q     <= cnt_nx;
          if (close) begin
            if (ov_nx) begin
              // H/crc/cnt freeze in DRAIN; status is taken from them on exit.
              state_q <= ST_DRAIN;
              pend_q  <= start_i;
            end else begin
              done_o    <= 1'b1;
              pec_ok_o  <= hv_nx & (crc_nx == h_nx);
              short_o   <= !hv_nx;
              len_o     <= cnt_nx;
              state_q   <= start_i ? ST_FRAME : ST_IDLE;
              crc_q     <= PecInit;
              cnt_q     <= '0;
              h_valid_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (start_i) pend_q <= 1'b1;
          if (out_hs) begin
            out_valid_o <= 1'b0;
            done_o      <= 1'b1;
            pec_ok_o    <= h_valid_q & (crc_q == h_q);
            short_o     <= !h_valid_q;
            len_o       <= cnt_q;
            state_q     <= (pend_q | start_i) ? ST_FRAME : ST_IDLE;
            pend_q      <= 1'b0;
            crc_q       <= PecInit;
            cnt_q       <= '0;
            h_valid_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_pec_checker.sv
// Bench for recovery_pec_checker: frame-level reference model (byte queues,
// bit-serial CRC-8) compared every cycle, plus directed literal checks.
module tb_recovery_pec_checker;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i, stop_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [7:0] in_data_i, out_data_o;
  logic       done_o, pec_ok_o, short_o;
  logic [7:0] len_o;

  recovery_pec_checker #(.PecInit(8'h00), .LenW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .done_o(done_o), .pec_ok_o(pec_ok_o), .short_o(short_o), .len_o(len_o)
  );

  always #5 clk_i = ~clk_i;

  typedef logic [7:0] bq_t [$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 = outside frame, 1 = in frame, 2 = waiting for last payload byte.
  int         m_mode;
  bq_t        fb;
  logic       m_ov, m_done, m_ok, m_short, m_pend, s_ok, s_short;
  logic [7:0] m_od, m_len, s_len;

  bq_t        got;
  logic [9:0] done_log [$];

  function automatic logic [7:0] crc8(input bq_t q, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c ^= q[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; fb.delete(); m_ov = 0; m_od = 0; m_done = 0; m_ok = 0;
    m_short = 0; m_len = 0; m_pend = 0; s_ok = 0; s_short = 0; s_len = 0;
  endtask

  task automatic status_of(input bq_t q, output logic ok, output logic sh, output logic [7:0] ln);
    sh = (q.size() == 0);
    ln = sh ? 8'd0 : ((q.size() - 1 > 255) ? 8'd255 : 8'(q.size() - 1));
    ok = !sh && (crc8(q, q.size() - 1) == q[q.size() - 1]);
  endtask

  task automatic model_step(input logic st, input logic sp, input logic iv,
                            input logic [7:0] d, input logic ordy);
    logic rdy, acc, hs, ok, sh;
    logic [7:0] ln;
    rdy = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? (!m_ov | ordy) : 1'b0;
    acc = iv & rdy;
    hs  = m_ov & ordy;
    m_done = 0;
    if (m_mode == 0) begin
      if (st) begin
        m_mode = 1;
        fb.delete();
        if (acc) fb.push_back(d);
      end
    end else if (m_mode == 1) begin
      if (hs) m_ov = 0;
      if (acc) begin
        if (fb.size() > 0) begin
          m_ov = 1;
          m_od = fb[$];
        end
        fb.push_back(d);
      end
      if (st | sp) begin
        status_of(fb, ok, sh, ln);
        if (m_ov) begin
          m_mode = 2; m_pend = st; s_ok = ok; s_short = sh; s_len = ln;
        end else begin
          m_done = 1; m_ok = ok; m_short = sh; m_len = ln;
          m_mode = st ? 1 : 0;
          fb.delete();
        end
      end
    end else begin
      if (st) m_pend = 1;
      if (hs) begin
        m_ov = 0; m_done = 1; m_ok = s_ok; m_short = s_short; m_len = s_len;
        m_mode = m_pend ? 1 : 0;
        m_pend = 0;
        fb.delete();
      end
    end
  endtask

  // Called at a falling edge; inputs are applied, outputs compared, model advanced.
  task automatic step(input logic st, input logic sp, input logic iv,
                      input logic [7:0] d, input logic ordy, output logic acc);
    logic exp_rdy;
    start_i = st; stop_i = sp; in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
    #1;
    exp_rdy = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? (!m_ov | ordy) : 1'b0;
    chk("in_ready", in_ready_o, exp_rdy);
    chk("out_valid", out_valid_o, m_ov);
    chk("out_data", out_data_o, m_od);
    chk("done", done_o, m_done);
    chk("pec_ok", pec_ok_o, m_ok);
    chk("short", short_o, m_short);
    chk("len", len_o, m_len);
    acc = in_valid_i & in_ready_o;
    if (out_valid_o & out_ready_i) got.push_back(out_data_o);
    if (done_o) done_log.push_back({pec_ok_o, short_o, len_o});
    @(posedge clk_i);
    model_step(st, sp, iv, d, ordy);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    repeat (n) step(0, 0, 0, 8'h00, ordy, a);
  endtask

  task automatic send(input logic [7:0] d, input logic ordy);
    logic a;
    int k;
    k = 0;
    do begin
      step(0, 0, 1, d, ordy, a);
      k++;
    end while (!a && k < 20);
    if (!a) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", d, k);
    end
  endtask

  task automatic clear_logs();
    got.delete();
    done_log.delete();
  endtask

  task automatic frame_ok_1();
    logic a;
    clear_logs();
    step(1, 0, 0, 8'h00, 1, a);
    send(8'h01, 1); send(8'h07, 1);
    step(0, 1, 0, 8'h00, 1, a);
    idle(3, 1);
    chk("t1_nout", got.size(), 1);
    if (got.size() >= 1) chk("t1_byte", got[0], 8'h01);
    chk("t1_ndone", done_log.size(), 1);
    if (done_log.size() >= 1) chk("t1_status", done_log[0], {1'b1, 1'b0, 8'd1});
  endtask

  initial begin
    logic a;
    bq_t  lq;
    rst_i = 1; start_i = 0; stop_i = 0; in_valid_i = 0; in_data_i = 0; out_ready_i = 0;
    model_reset();
    @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_status", {pec_ok_o, short_o, len_o}, 0);
    rst_i = 0;

    frame_ok_1();

    // 01,02 with good PEC 1B, then bad PEC 1C
    for (int t = 0; t < 2; t++) begin
      clear_logs();
      step(1, 0, 0, 8'h00, 1, a);
      send(8'h01, 1); send(8'h02, 1); send(t == 0 ? 8'h1B : 8'h1C, 1);
      step(0, 1, 0, 8'h00, 1, a);
      idle(3, 1);
      chk("t2_nout", got.size(), 2);
      if (got.size() == 2) chk("t2_bytes", {got[0], got[1]}, 16'h0102);
      chk("t2_ndone", done_log.size(), 1);
      if (done_log.size() >= 1) chk("t2_status", done_log[0], {t == 0, 1'b0, 8'd2});
    end

    // empty frame
    clear_logs();
    step(1, 0, 0, 8'h00, 1, a);
    step(0, 1, 0, 8'h00, 1, a);
    idle(3, 1);
    chk("t3_nout", got.size(), 0);
    chk("t3_ndone", done_log.size(), 1);
    if (done_log.size() >= 1) chk("t3_status", done_log[0], {1'b0, 1'b1, 8'd0});

    // backpressure into DRAIN
    clear_logs();
    step(1, 0, 0, 8'h00, 0, a);
    send(8'h01, 0); send(8'h02, 0);
    step(0, 0, 1, 8'h1B, 0, a); chk("t4_stall0", a, 0);
    step(0, 0, 1, 8'h1B, 0, a); chk("t4_stall1", a, 0);
    step(0, 0, 1, 8'h1B, 1, a); chk("t4_accept", a, 1);
    step(0, 1, 0, 8'h00, 0, a);
    idle(3, 0);
    chk("t4_drain_ready", in_ready_o, 0);
    chk("t4_no_done", done_log.size(), 0);
    idle(3, 1);
    chk("t4_nout", got.size(), 2);
    if (got.size() == 2) chk("t4_bytes", {got[0], got[1]}, 16'h0102);
    chk("t4_ndone", done_log.size(), 1);
    if (done_log.size() >= 1) chk("t4_status", done_log[0], {1'b1, 1'b0, 8'd2});

    // repeated start, then start during DRAIN
    for (int t = 0; t < 2; t++) begin
      clear_logs();
      step(1, 0, 0, 8'h00, t == 0, a);
      send(8'h01, t == 0); send(8'h07, t == 0);
      if (t == 0) begin
        step(1, 0, 0, 8'h00, 1, a);
      end else begin
        step(0, 1, 0, 8'h00, 0, a);
        step(1, 0, 0, 8'h00, 0, a);
        step(0, 0, 0, 8'h00, 1, a);
      end
      send(8'h01, 1); send(8'h07, 1);
      step(0, 1, 0, 8'h00, 1, a);
      idle(3, 1);
      chk("t5_ndone", done_log.size(), 2);
      if (done_log.size() == 2) begin
        chk("t5_status0", done_log[0], {1'b1, 1'b0, 8'd1});
        chk("t5_status1", done_log[1], {1'b1, 1'b0, 8'd1});
      end
      chk("t5_nout", got.size(), 2);
    end

    // asynchronous reset mid-frame
    step(1, 0, 0, 8'h00, 0, a);
    send(8'h01, 0); send(8'h02, 0);
    #2 rst_i = 1;
    #1;
    chk("t6_out_valid", out_valid_o, 0);
    chk("t6_out_data", out_data_o, 0);
    chk("t6_in_ready", in_ready_o, 1);
    chk("t6_done", done_o, 0);
    chk("t6_status", {pec_ok_o, short_o, len_o}, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 0;
    frame_ok_1();

    // long frame: length saturates at 255
    clear_logs();
    lq.delete();
    for (int i = 0; i < 299; i++) lq.push_back(8'($urandom));
    lq.push_back(crc8(lq, 299));
    step(1, 0, 0, 8'h00, 1, a);
    foreach (lq[i]) send(lq[i], 1);
    step(0, 1, 0, 8'h00, 1, a);
    idle(3, 1);
    chk("t7_nout", got.size(), 299);
    chk("t7_ndone", done_log.size(), 1);
    if (done_log.size() >= 1) chk("t7_status", done_log[0], {1'b1, 1'b0, 8'd255});

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic st, sp, iv, ordy;
      logic [7:0] d;
      st   = ($urandom_range(0, 99) < 5);
      sp   = ($urandom_range(0, 99) < 5);
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 70);
      d    = ($urandom_range(0, 2) == 0) ? crc8(fb, fb.size()) : 8'($urandom);
      step(st, sp, iv, d, ordy, a);
    end
    idle(5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
